multicycle_main_fsm: RTL
========================

# multicycle_main_fsm

Parametrised successor to the RV32I multicycle main controller. It sequences fetch, decode, execute, memory and writeback for every base-ISA control-flow and load/store class. It supports variable-latency memory through a ready handshake, resolves all six branch conditions, and retires instructions into a counter. It sits between the instruction register / ALU flags and the datapath muxes of the multicycle core.

## Interface
- EXT_ISA, 1: 1 enables jalr/lui/auipc and blt/bge/bltu/bgeu; 0 treats them as illegal
- MEM_WAIT, 1: 1 honours mem_ready; 0 ties it internally to 1
- TRAP_EN, 1: 1 makes illegal opcodes halt in TRAP; 0 skips them back to FETCH
- CNT_W, 32: retired-instruction counter width
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register
- funct3  in  3  funct3 from instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch  out  1 each  datapath strobes/selects
- PCWrite  out  1  PCUpdate | (Branch & taken)
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  illegal opcode/funct3 flag
- instr_retired  out  1  one-cycle pulse on final cycle of each instruction
- retired_count  out  CNT_W  wrapping retire count
- state  out  4  current state encoding (debug)

## Operation
- Encodings: ALUSrcA 00 PC, 01 OldPC, 10 rs1; ALUSrcB 00 rs2, 01 ImmExt, 10 const 4; ResultSrc 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt; ALUOp 00 add, 01 sub, 10 funct-decoded, 11 funct3 compare.
- All outputs are fully defaulted to 0 every state and decoded from state only, plus op/funct3/Zero/mem_ready as noted. No latches.
- ImmSrc is decoded from op in every state: lw/I/jalr I, sw S, branch B, jal J, lui/auipc U, else 000.
- FETCH (0): AdrSrc0, A00, B10, ALUOp00, ResultSrc10. IRWrite and PCUpdate assert only when mem_ready. Next state is DECODE on mem_ready, else FETCH.
- DECODE (1): A01, B01, ALUOp00. Next state by op:
  - 0000011 → MEMADR; 0100011 → MEMADR
  - 0110011 → EXECR; 0010011 → EXECI
  - 1100011 → BRANCH; 1101111 → JAL
  - EXT_ISA only: 1100111 → JALR, 0110111 → LUI, 0010111 → AUIPC
  - else illegal.
- Branch funct3 010/011, or 1xx with EXT_ISA=0, is illegal.
- Illegal: illegal=1 in DECODE. TRAP_EN=1 → TRAP (14), which drives all strobes 0, holds illegal=1 and stays until reset. TRAP_EN=0 → FETCH.
- MEMADR (2): A10, B01, ALUOp00. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD (3): AdrSrc1, ResultSrc00. Holds until mem_ready, then → MEMWB.
- MEMWB (4): ResultSrc01, RegWrite → FETCH.
- MEMWRITE (5): AdrSrc1, ResultSrc00, MemWrite held high while waiting. → FETCH on mem_ready.
- EXECR (6): A10, B00, ALUOp10 → ALUWB. EXECI (8): A10, B01, ALUOp10 → ALUWB.
- ALUWB (7): ResultSrc00, RegWrite → FETCH.
- JAL (9): A01, B10, ALUOp00, ResultSrc00, PCUpdate → ALUWB.
- JALR (11): A10, B01, ALUOp00 → JAL.
- LUI (12): ResultSrc11, RegWrite → FETCH.
- AUIPC (13): A01, B01, ALUOp00 → ALUWB.
- BRANCH (10): A10, B00, ResultSrc00, Branch=1. ALUOp=01 for funct3 00x, 11 for 1xx. taken = Zero ^ funct3[0] ^ funct3[2]. → FETCH.
- Unused encoding 15 → FETCH with all outputs 0.
- instr_retired pulses in MEMWB, ALUWB, LUI, BRANCH, and in MEMWRITE when mem_ready=1. retired_count increments the following edge and wraps to 0 from all-ones.

## Timing
- Reset (async assert, sync-to-clk deassert by system): state=FETCH, retired_count=0, illegal=0. Outputs show FETCH decode: IRWrite/PCUpdate/PCWrite follow mem_ready.
- Zero-wait cycle counts:
  - lw 5, sw 4, R/I 4, jal 4, branch 3
  - jalr 5, lui 3, auipc 4
- Each cycle of mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one cycle. No strobe other than MemWrite/AdrSrc changes while waiting.
- reset_n low mid-instruction aborts immediately. No partial RegWrite/MemWrite after assertion.
- Counter update and illegal-to-TRAP transition are registered: one edge after the triggering cycle.

## Test plan
- Reset then add R-type (op 0110011), mem_ready=1 → states 0,1,6,7,0. RegWrite only in state 7. retired_count=1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. IRWrite single pulse. RegWrite with ResultSrc01 once.
- bne (funct3 001), Zero=0 → PCWrite=1 in BRANCH, ALUOp01. Same with Zero=1 → PCWrite=0. bge (101), Zero=1 → PCWrite=1, ALUOp11.
- jalr → states 1,11,9,7. PCWrite in FETCH and JAL. ImmSrc=000 throughout. lui → RegWrite, ResultSrc11, ImmSrc100 in 3 cycles.
- op 1111111 with TRAP_EN=1 → illegal, state 14 held 20 cycles, no strobes. reset_n low → FETCH, illegal=0.
- CNT_W=4: retire 17 instructions → retired_count=1. Assert reset_n mid-MEMWRITE → MemWrite drops same cycle, count=0.

Source files
------------

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the multicycle main controller and the core datapath.
// The controller drives through the master modport; the datapath connects as slave.
interface multicycle_main_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             Zero;
  logic             mem_ready;
  logic             MemWrite;
  logic             RegWrite;
  logic             IRWrite;
  logic             AdrSrc;
  logic             PCUpdate;
  logic             Branch;
  logic             PCWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [2:0]       ImmSrc;
  logic             illegal;
  logic             instr_retired;
  logic [CNT_W-1:0] retired_count;
  logic [3:0]       state;

  modport master (
    input  op, funct3, Zero, mem_ready,
    output MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch, PCWrite,
    output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    output illegal, instr_retired, retired_count, state
  );

  modport slave (
    output op, funct3, Zero, mem_ready,
    input  MemWrite, RegWrite, IRWrite, AdrSrc, PCUpdate, Branch, PCWrite,
    input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
    input  illegal, instr_retired, retired_count, state
  );
endinterface

// File: rtl/multicycle_main_fsm.sv
// RV32I multicycle main controller: sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready, resolves branches and counts retired instructions.
module multicycle_main_fsm #(
  parameter bit          EXT_ISA  = 1'b1,
  parameter bit          MEM_WAIT = 1'b1,
  parameter bit          TRAP_EN  = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  multicycle_main_fsm_if.master bus
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBranch   = 4'd10,
    StJalr     = 4'd11,
    StLui      = 4'd12,
    StAuipc    = 4'd13,
    StTrap     = 4'd14
  } state_e;

  state_e           state_q, state_d, dec_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_rdy, br_ok, dec_illegal, taken;
  logic             mem_write, reg_write, ir_write, adr_src, pc_update, branch;
  logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]       imm_dec, imm_src;
  logic             illegal, retired;

  assign mem_rdy = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign br_ok   = (bus.funct3[2:1] == 2'b00) || (EXT_ISA && bus.funct3[2]);
  // beq/bne test Zero directly; the 1xx compares invert the sense via funct3[2].
  assign taken   = bus.Zero ^ bus.funct3[0] ^ bus.funct3[2];

  always_comb begin
    case (bus.op)
      OpLoad, OpImm, OpJalr: imm_dec = 3'b000;
      OpStore:               imm_dec = 3'b001;
      OpBranch:              imm_dec = 3'b010;
      OpJal:                 imm_dec = 3'b011;
      OpLui, OpAuipc:        imm_dec = 3'b100;
      default:               imm_dec = 3'b000;
    endcase
  end

  always_comb begin
    dec_illegal = 1'b0;
    dec_next    = StFetch;
    case (bus.op)
      OpLoad, OpStore: dec_next = StMemAdr;
      OpReg:           dec_next = StExecR;
      OpImm:           dec_next = StExecI;
      OpJal:           dec_next = StJal;
      OpBranch: begin
        if (br_ok) dec_next = StBranch;
        else       dec_illegal = 1'b1;
      end
      OpJalr: begin
        if (EXT_ISA) dec_next = StJalr;
        else         dec_illegal = 1'b1;
      end
      OpLui: begin
        if (EXT_ISA) dec_next = StLui;
        else         dec_illegal = 1'b1;
      end
      OpAuipc: begin
        if (EXT_ISA) dec_next = StAuipc;
        else         dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec_next = TRAP_EN ? StTrap : StFetch;
  end

  always_comb begin
    state_d    = state_q;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = imm_dec;
    illegal    = 1'b0;
    retired    = 1'b0;
    case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_rdy;
        pc_update  = mem_rdy;
        if (mem_rdy) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = dec_illegal;
        state_d   = dec_next;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (mem_rdy) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retired    = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) begin
          retired = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StJalr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = StJal;
      end
      StLui: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        retired    = 1'b1;
        state_d    = StFetch;
      end
      StAuipc: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = StAluWb;
      end
      StBranch: begin
        alu_src_a = 2'b10;
        branch    = 1'b1;
        alu_op    = bus.funct3[2] ? 2'b11 : 2'b01;
        retired   = 1'b1;
        state_d   = StFetch;
      end
      StTrap: illegal = 1'b1;
      default: begin
        imm_src = 3'b000;
        state_d = StFetch;
      end
    endcase
  end

  assign cnt_d = cnt_q + CNT_W'(retired);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.MemWrite      = mem_write;
  assign bus.RegWrite      = reg_write;
  assign bus.IRWrite       = ir_write;
  assign bus.AdrSrc        = adr_src;
  assign bus.PCUpdate      = pc_update;
  assign bus.Branch        = branch;
  assign bus.PCWrite       = pc_update | (branch & taken);
  assign bus.ResultSrc     = result_src;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ALUOp         = alu_op;
  assign bus.ImmSrc        = imm_src;
  assign bus.illegal       = illegal;
  assign bus.instr_retired = retired;
  assign bus.retired_count = cnt_q;
  assign bus.state         = state_q;

endmodule
